// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor built from a table of 2^INDEX_WIDTH saturating
// counters indexed by the fetch PC.  The lookup index travels down the
// F -> D -> E pipeline with a valid bit, so the counter that produced a
// prediction is the one trained when the branch resolves in Execute.
//
// Optional build macro: BRANCH_PREDICTOR_GSHARE_EN
//   When defined, an INDEX_WIDTH-bit global history register is XORed into
//   the fetch index (gshare).  History is shifted only on a resolved branch,
//   so flushes never disturb it.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   PCF          in   fetch-stage PC (bits [1:0] ignored)
//   StallD       in   hold the Decode-stage index register
//   FlushD       in   invalidate the Decode-stage index register
//   FlushE       in   invalidate the Execute-stage index register
//   BranchOpEb0  in   conditional branch present in Execute
//   PCSrcResE    in   resolved direction in Execute (1 = taken)
//   PCSrcPredF   out  predicted direction for PCF (combinational)
//   IndexE       out  table index carried by the Execute-stage slot
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int INDEX_WIDTH   = 6,
    parameter int COUNTER_WIDTH = 2,
    parameter int PC_WIDTH      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PC_WIDTH-1:0]    PCF,
    input  logic                   StallD,
    input  logic                   FlushD,
    input  logic                   FlushE,
    input  logic                   BranchOpEb0,
    input  logic                   PCSrcResE,
    output logic                   PCSrcPredF,
    output logic [INDEX_WIDTH-1:0] IndexE
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    // Weakly not-taken: MSB clear, all lower bits set (01 for 2-bit).
    localparam logic [COUNTER_WIDTH-1:0] CNT_INIT = {1'b0, {(COUNTER_WIDTH-1){1'b1}}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_MIN  = '0;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic [COUNTER_WIDTH-1:0] r_table [DEPTH];

    logic [INDEX_WIDTH-1:0]   r_idx_d;
    logic                     r_valid_d;
    logic [INDEX_WIDTH-1:0]   r_idx_e;
    logic                     r_valid_e;

    logic [INDEX_WIDTH-1:0]   w_idx_f;
    logic                     w_update;
    logic [COUNTER_WIDTH-1:0] w_cnt_e;
    logic [COUNTER_WIDTH-1:0] w_cnt_next;

    // PC bits outside the index field do not take part in the lookup.
    logic w_unused_pc;
    assign w_unused_pc = ^{PCF[PC_WIDTH-1:INDEX_WIDTH+2], PCF[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [INDEX_WIDTH-1:0] r_ghr;
    assign w_idx_f = PCF[INDEX_WIDTH+1:2] ^ r_ghr;
`else
    assign w_idx_f = PCF[INDEX_WIDTH+1:2];
`endif

    // Read port: no bypass from a same-cycle update; the new value appears
    // on the following cycle.
    assign PCSrcPredF = r_table[w_idx_f][COUNTER_WIDTH-1];
    assign IndexE     = r_idx_e;

    // Bubbles and flushed slots have valid=0 and therefore never train.
    assign w_update = BranchOpEb0 && r_valid_e;
    assign w_cnt_e  = r_table[r_idx_e];

    always_comb begin
        w_cnt_next = w_cnt_e;
        if (PCSrcResE) begin
            if (w_cnt_e != CNT_MAX) w_cnt_next = w_cnt_e + CNT_ONE;
        end else begin
            if (w_cnt_e != CNT_MIN) w_cnt_next = w_cnt_e - CNT_ONE;
        end
    end

    // Counter table: reset wins over a concurrent update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= CNT_INIT;
            end
        end else if (w_update) begin
            r_table[r_idx_e] <= w_cnt_next;
        end
    end

    // Decode-stage index register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx_d   <= '0;
            r_valid_d <= 1'b0;
        end else if (FlushD) begin
            r_idx_d   <= '0;
            r_valid_d <= 1'b0;
        end else if (!StallD) begin
            r_idx_d   <= w_idx_f;
            r_valid_d <= 1'b1;
        end
    end

    // Execute-stage index register: never stalls, always advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx_e   <= '0;
            r_valid_e <= 1'b0;
        end else if (FlushE) begin
            r_idx_e   <= '0;
            r_valid_e <= 1'b0;
        end else begin
            r_idx_e   <= r_idx_d;
            r_valid_e <= r_valid_d;
        end
    end

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    // Non-speculative history: shifted only when a branch resolves.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (w_update) begin
            r_ghr <= {r_ghr[INDEX_WIDTH-2:0], PCSrcResE};
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] PCF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic        BranchOpEb0;
  logic        PCSrcResE;
  logic        PCSrcPredF;
  logic [5:0]  IndexE;

  int checks;
  int failures;

  logic [5:0] exp_q[$];

  branch_predictor #(
    .INDEX_WIDTH  (6),
    .COUNTER_WIDTH(2),
    .PC_WIDTH     (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .PCF        (PCF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .BranchOpEb0(BranchOpEb0),
    .PCSrcResE  (PCSrcResE),
    .PCSrcPredF (PCSrcPredF),
    .IndexE     (IndexE)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one rising edge, then return at the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    StallD      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    BranchOpEb0 = 1'b0;
    PCSrcResE   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // drive one resolved branch through a single edge
  task automatic resolve(input logic taken);
    BranchOpEb0 = 1'b1;
    PCSrcResE   = taken;
    tick();
    BranchOpEb0 = 1'b0;
    PCSrcResE   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] pc;
    idle_inputs();
    reset = 1'b1;
    PCF   = 32'h0;
    tick();
    for (int i = 0; i < 64; i++) begin
      pc  = i * 4;
      PCF = pc;
      #1;
      checks++;
      if (PCSrcPredF !== 1'b0) begin
        failures++;
        $display("FAIL reset_pred pc=%h got=%b exp=0", pc, PCSrcPredF);
      end
    end
    checks++;
    if (IndexE !== 6'd0) begin
      failures++;
      $display("FAIL reset_indexe got=%0d exp=0", IndexE);
    end
    // With D held flushed, E must stay invalid: a taken resolve must not train entry 0.
    reset       = 1'b0;
    PCF         = 32'h0;
    FlushD      = 1'b1;
    BranchOpEb0 = 1'b1;
    PCSrcResE   = 1'b1;
    tick();
    tick();
    tick();
    idle_inputs();
    #1;
    checks++;
    if (PCSrcPredF !== 1'b0) begin
      failures++;
      $display("FAIL reset_valide_no_train got=%b exp=0", PCSrcPredF);
    end
  endtask

  task automatic test_train_taken();
    do_reset();
    PCF = 32'h40;
    tick();
    tick();
    checks++;
    if (IndexE !== 6'd16) begin
      failures++;
      $display("FAIL train_indexe got=%0d exp=16", IndexE);
    end
    resolve(1'b1);              // 01 -> 10
    #1;
    checks++;
    if (PCSrcPredF !== 1'b1) begin
      failures++;
      $display("FAIL train_first_taken got=%b exp=1", PCSrcPredF);
    end
    resolve(1'b1);              // 10 -> 11
    resolve(1'b1);              // 11 stays 11
    #1;
    checks++;
    if (PCSrcPredF !== 1'b1) begin
      failures++;
      $display("FAIL train_sat_high got=%b exp=1", PCSrcPredF);
    end
    resolve(1'b0);              // 11 -> 10
    #1;
    checks++;
    if (PCSrcPredF !== 1'b1) begin
      failures++;
      $display("FAIL train_sat_high_step got=%b exp=1", PCSrcPredF);
    end
    resolve(1'b0);              // 10 -> 01
    #1;
    checks++;
    if (PCSrcPredF !== 1'b0) begin
      failures++;
      $display("FAIL train_back_weak got=%b exp=0", PCSrcPredF);
    end
  endtask

  // continues from entry 16 = 01 with PCF=0x40 and E carrying idx 16
  task automatic test_saturate_low();
    resolve(1'b0);              // 01 -> 00
    resolve(1'b0);              // 00 stays 00
    #1;
    checks++;
    if (PCSrcPredF !== 1'b0) begin
      failures++;
      $display("FAIL sat_low got=%b exp=0", PCSrcPredF);
    end
    PCF = 32'h140;
    #1;
    checks++;
    if (PCSrcPredF !== 1'b0) begin
      failures++;
      $display("FAIL sat_low_alias got=%b exp=0", PCSrcPredF);
    end
    PCF = 32'h40;
    resolve(1'b1);              // 00 -> 01
    #1;
    checks++;
    if (PCSrcPredF !== 1'b0) begin
      failures++;
      $display("FAIL sat_low_up1 got=%b exp=0", PCSrcPredF);
    end
    resolve(1'b1);              // 01 -> 10
    #1;
    checks++;
    if (PCSrcPredF !== 1'b1) begin
      failures++;
      $display("FAIL sat_low_up2 got=%b exp=1", PCSrcPredF);
    end
    PCF = 32'h140;
    #1;
    checks++;
    if (PCSrcPredF !== 1'b1) begin
      failures++;
      $display("FAIL alias_0x140 got=%b exp=1", PCSrcPredF);
    end
    PCF = 32'h43;
    #1;
    checks++;
    if (PCSrcPredF !== 1'b1) begin
      failures++;
      $display("FAIL low_bits_ignored got=%b exp=1", PCSrcPredF);
    end
    PCF = 32'h44;
    #1;
    checks++;
    if (PCSrcPredF !== 1'b0) begin
      failures++;
      $display("FAIL neighbour_idx17 got=%b exp=0", PCSrcPredF);
    end
  endtask

  task automatic test_flush_stall();
    logic [5:0] exp_idx;
    // flush: the branch heading into E is dropped and never trains
    do_reset();
    PCF = 32'h80;
    tick();                     // D = {32,1}
    FlushE      = 1'b1;
    FlushD      = 1'b1;
    BranchOpEb0 = 1'b1;
    PCSrcResE   = 1'b1;
    tick();                     // E flushed, D flushed
    checks++;
    if (IndexE !== 6'd0) begin
      failures++;
      $display("FAIL flush_indexe got=%0d exp=0", IndexE);
    end
    FlushE = 1'b0;
    tick();                     // E takes the flushed D bubble
    idle_inputs();
    #1;
    checks++;
    if (PCSrcPredF !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_train got=%b exp=0", PCSrcPredF);
    end

    // stall: D holds idx 48 while the PC moves on
    do_reset();
    PCF = 32'hC0;
    tick();                     // D = {48,1}
    StallD = 1'b1;
    PCF    = 32'h04;
    for (int i = 0; i < 3; i++) exp_q.push_back(6'd48);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_idx = exp_q.pop_front();
      checks++;
      if (IndexE !== exp_idx) begin
        failures++;
        $display("FAIL stall_indexe cyc=%0d got=%0d exp=%0d", i, IndexE, exp_idx);
      end
    end
    StallD = 1'b0;
    exp_q.push_back(6'd48);
    exp_q.push_back(6'd1);
    resolve(1'b1);              // trains entry 48, D loads idx 1
    exp_idx = exp_q.pop_front();
    checks++;
    if (IndexE !== exp_idx) begin
      failures++;
      $display("FAIL stall_release_indexe got=%0d exp=%0d", IndexE, exp_idx);
    end
    PCF = 32'hC0;
    #1;
    checks++;
    if (PCSrcPredF !== 1'b1) begin
      failures++;
      $display("FAIL stall_trained_48 got=%b exp=1", PCSrcPredF);
    end
    PCF = 32'h04;
    #1;
    checks++;
    if (PCSrcPredF !== 1'b0) begin
      failures++;
      $display("FAIL stall_untouched_1 got=%b exp=0", PCSrcPredF);
    end
    tick();
    exp_idx = exp_q.pop_front();
    checks++;
    if (IndexE !== exp_idx) begin
      failures++;
      $display("FAIL stall_after_indexe got=%0d exp=%0d", IndexE, exp_idx);
    end
  endtask

  task automatic test_collision();
    do_reset();
    PCF = 32'h10;               // idx 4
    tick();
    tick();
    BranchOpEb0 = 1'b1;
    PCSrcResE   = 1'b1;
    #1;
    checks++;
    if (PCSrcPredF !== 1'b0) begin
      failures++;
      $display("FAIL collide_old got=%b exp=0", PCSrcPredF);
    end
    tick();
    BranchOpEb0 = 1'b0;
    #1;
    checks++;
    if (PCSrcPredF !== 1'b1) begin
      failures++;
      $display("FAIL collide_new got=%b exp=1", PCSrcPredF);
    end
    // reset together with a valid taken update: update dropped, entry back to 01
    reset       = 1'b1;
    BranchOpEb0 = 1'b1;
    PCSrcResE   = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (PCSrcPredF !== 1'b0) begin
      failures++;
      $display("FAIL reset_with_update got=%b exp=0", PCSrcPredF);
    end
    checks++;
    if (IndexE !== 6'd0) begin
      failures++;
      $display("FAIL reset_with_update_indexe got=%0d exp=0", IndexE);
    end
    tick();
    tick();
    resolve(1'b1);              // 01 -> 10 only if reset restored 01
    #1;
    checks++;
    if (PCSrcPredF !== 1'b1) begin
      failures++;
      $display("FAIL reset_restored_weak got=%b exp=1", PCSrcPredF);
    end
  endtask

  task automatic test_gshare();
    do_reset();
    PCF = 32'h0;
    tick();
    tick();                     // E = {0,1}
    resolve(1'b1);              // entry0 10, GHR 000001
    resolve(1'b1);              // entry0 11, GHR 000011
    resolve(1'b0);              // entry0 10, GHR 000110
    #1;
    checks++;
    if (PCSrcPredF !== 1'b0) begin
      failures++;
      $display("FAIL gshare_idx6_pred got=%b exp=0", PCSrcPredF);
    end
    PCF = 32'h18;               // 6 ^ 6 = 0
    #1;
    checks++;
    if (PCSrcPredF !== 1'b1) begin
      failures++;
      $display("FAIL gshare_idx0_pred got=%b exp=1", PCSrcPredF);
    end
    PCF = 32'h0;
    tick();
    tick();
    checks++;
    if (IndexE !== 6'd6) begin
      failures++;
      $display("FAIL gshare_indexe got=%0d exp=6", IndexE);
    end
    resolve(1'b1);              // entry6 10, GHR 001101
    PCF = 32'h2C;               // 11 ^ 13 = 6
    #1;
    checks++;
    if (PCSrcPredF !== 1'b1) begin
      failures++;
      $display("FAIL gshare_trained_6 got=%b exp=1", PCSrcPredF);
    end
    PCF = 32'h34;               // 13 ^ 13 = 0, entry0 still 10
    #1;
    checks++;
    if (PCSrcPredF !== 1'b1) begin
      failures++;
      $display("FAIL gshare_entry0 got=%b exp=1", PCSrcPredF);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    PCF      = 32'h0;
    idle_inputs();
    @(negedge clk);
    test_reset();
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    test_gshare();
`else
    test_train_taken();
    test_saturate_low();
    test_flush_stall();
    test_collision();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
